// File: rtl/serial_decrementer.sv
// Multi-cycle decrementer: computes operand - 1 by rippling a borrow through
// CHUNK half-subtractor cells per clock, LSB chunk first, with start/ready/done.
module serial_decrementer #(
  parameter int N     = 32,
  parameter int CHUNK = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] operand,
  output logic         ready,
  output logic         done,
  output logic [N-1:0] result,
  output logic         underflow,
  output logic         zero
);

  localparam int NCH = N / CHUNK;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NCH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  state_t         state_next;
  logic [N-1:0]   work;
  logic [N-1:0]   work_next;
  logic           borrow;
  logic [IW-1:0]  idx;
  logic           last_chunk;

  logic [CHUNK-1:0] chunk_in;
  logic [CHUNK-1:0] chunk_out;
  logic [CHUNK:0]   bchain;

  assign last_chunk = (idx == LAST_IDX);

  // Half-subtractor chain over the current chunk: diff = a ^ b, bout = ~a & b.
  assign chunk_in  = work[int'(idx) * CHUNK +: CHUNK];
  assign bchain[0] = borrow;

  for (genvar i = 0; i < CHUNK; i++) begin : g_cell
    assign chunk_out[i]  = chunk_in[i] ^ bchain[i];
    assign bchain[i + 1] = ~chunk_in[i] & bchain[i];
  end

  always_comb begin
    work_next = work;
    work_next[int'(idx) * CHUNK +: CHUNK] = chunk_out;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_chunk) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    ready = (state == IDLE);
    done  = (state == DONE);
  end

  // Datapath; result and flags only move on the DONE-entry edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      work      <= '0;
      borrow    <= 1'b0;
      idx       <= '0;
      result    <= '0;
      underflow <= 1'b0;
      zero      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            work   <= operand;
            borrow <= 1'b1;
            idx    <= '0;
          end
        end
        RUN: begin
          work   <= work_next;
          borrow <= bchain[CHUNK];
          idx    <= idx + IW'(1);
          if (last_chunk) begin
            result    <= work_next;
            underflow <= bchain[CHUNK];
            zero      <= (work_next == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_decrementer.sv
// Bench for serial_decrementer: directed handshake/reset scenarios on CHUNK=4
// plus randomized operands on CHUNK=1/8/32, all checked through scoreboards.
module tb_serial_decrementer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] operand;
  logic        ready;
  logic        done;
  logic [31:0] result;
  logic        underflow;
  logic        zero;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_acc    = 0;
  logic sweep_go = 1'b0;

  logic [33:0] exp_q[$];
  time         acc_q[$];
  time         acc_log[$];
  logic [33:0] mon_e;
  time         mon_t;

  always #5 clk = ~clk;

  serial_decrementer #(.N(32), .CHUNK(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .operand   (operand),
    .ready     (ready),
    .done      (done),
    .result    (result),
    .underflow (underflow),
    .zero      (zero)
  );

  // Reference: {underflow, zero, result} from plain modular subtraction.
  function automatic logic [33:0] model(input logic [31:0] op);
    logic [31:0] r;
    logic        uf;
    logic        z;
    r  = op - 32'd1;
    uf = (op == 32'd0);
    z  = (r == 32'd0);
    return {uf, z, r};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Accept monitor: inputs change only just after posedge, so the negedge
  // view of start/ready is what the next rising edge will act on.
  always @(negedge clk) begin
    if (!rst && start && ready) begin
      exp_q.push_back(model(operand));
      acc_q.push_back($time + 5);
      acc_log.push_back($time + 5);
      n_acc++;
    end
  end

  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", done, 1'b0);
      end else begin
        mon_e = exp_q.pop_front();
        mon_t = acc_q.pop_front();
        check("result", result, mon_e[31:0]);
        check("underflow", underflow, mon_e[33]);
        check("zero", zero, mon_e[32]);
        check("latency", ($time - 5 - mon_t) / 10, 8);
        check("ready_in_done", ready, 1'b0);
      end
    end
  end

  task automatic send(input logic [31:0] op);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    start   = 1'b1;
    operand = op;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("accept_timeout", ready, 1'b1);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (ready && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("idle_timeout", exp_q.size(), 0);
  endtask

  for (genvar g = 0; g < 3; g++) begin : sw
    localparam int CH = (g == 0) ? 1 : ((g == 1) ? 8 : 32);
    logic        start_s;
    logic [31:0] op_s;
    logic        rdy_s;
    logic        done_s;
    logic [31:0] res_s;
    logic        uf_s;
    logic        z_s;
    logic        fin;
    logic [33:0] exp_q[$];
    time         acc_q[$];
    logic [33:0] e;
    time         t;

    serial_decrementer #(.N(32), .CHUNK(CH)) d (
      .clk       (clk),
      .rst       (rst),
      .start     (start_s),
      .operand   (op_s),
      .ready     (rdy_s),
      .done      (done_s),
      .result    (res_s),
      .underflow (uf_s),
      .zero      (z_s)
    );

    always @(negedge clk) begin
      if (!rst && start_s && rdy_s) begin
        exp_q.push_back(model(op_s));
        acc_q.push_back($time + 5);
      end
    end

    always @(negedge clk) begin
      if (!rst && done_s) begin
        if (exp_q.size() == 0) begin
          check($sformatf("c%0d_spurious_done", CH), done_s, 1'b0);
        end else begin
          e = exp_q.pop_front();
          t = acc_q.pop_front();
          check($sformatf("c%0d_result", CH), res_s, e[31:0]);
          check($sformatf("c%0d_underflow", CH), uf_s, e[33]);
          check($sformatf("c%0d_zero", CH), z_s, e[32]);
          check($sformatf("c%0d_latency", CH), ($time - 5 - t) / 10, 32 / CH);
        end
      end
    end

    initial begin
      logic [31:0] v;
      int          sel;
      bit          got;
      start_s = 1'b0;
      op_s    = '0;
      fin     = 1'b0;
      wait (sweep_go);
      for (int n = 0; n < 20; n++) begin
        sel = $urandom_range(0, 5);
        case (sel)
          0:       v = 32'h0000_0000;
          1:       v = 32'h0000_0001;
          2:       v = 32'hFFFF_FFFF;
          default: v = $urandom;
        endcase
        repeat ($urandom_range(0, 3)) @(posedge clk);
        @(posedge clk); #1;
        start_s = 1'b1;
        op_s    = v;
        got     = 1'b0;
        for (int k = 0; k < 100; k++) begin
          @(negedge clk);
          if (rdy_s) begin
            got = 1'b1;
            break;
          end
        end
        if (!got) check($sformatf("c%0d_accept_timeout", CH), rdy_s, 1'b1);
        @(posedge clk); #1;
        start_s = 1'b0;
      end
      for (int k = 0; k < 200; k++) begin
        @(negedge clk);
        if (exp_q.size() == 0) break;
      end
      check($sformatf("c%0d_drain", CH), exp_q.size(), 0);
      fin = 1'b1;
    end
  end

  initial begin
    int base;
    bit seen;
    rst     = 1'b1;
    start   = 1'b0;
    operand = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", ready, 1'b1);
    check("rst_done", done, 1'b0);
    check("rst_result", result, 32'h0);
    check("rst_underflow", underflow, 1'b0);
    check("rst_zero", zero, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic operation with ready profile around the operation
    send(32'h0000_0010);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("ready_busy", ready, 1'b0);
    end
    @(negedge clk);
    check("done_cycle", done, 1'b1);
    check("ready_done_cycle", ready, 1'b0);
    @(negedge clk);
    check("ready_after_done", ready, 1'b1);
    check("done_cleared", done, 1'b0);

    // Underflow
    send(32'h0000_0000);
    wait_idle();

    // Start held high: two back-to-back operations, no extras
    base = n_acc;
    @(posedge clk); #1;
    start   = 1'b1;
    operand = 32'h0000_0001;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (n_acc == base + 1) break;
    end
    operand = 32'h8000_0000;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (n_acc == base + 2) break;
    end
    start = 1'b0;
    check("held_accepts", n_acc - base, 2);
    check("accept_spacing", acc_log[acc_log.size() - 1] - acc_log[acc_log.size() - 2], 100);
    repeat (15) @(posedge clk);
    check("no_extra_accept", n_acc - base, 2);
    wait_idle();

    // Start pulses while busy are ignored; result holds until DONE
    send(32'h0000_00A5);
    repeat (3) @(posedge clk);
    #1;
    start   = 1'b1;
    operand = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("hold_result", result, 32'h7FFF_FFFF);
    check("hold_underflow", underflow, 1'b0);
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) check("busy_done_timeout", done, 1'b1);
    #1;
    start   = 1'b1;
    operand = 32'h1111_1111;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle();
    repeat (12) @(negedge clk);

    // Reset in the middle of RUN aborts the operation
    send(32'h0000_0042);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    acc_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_ready", ready, 1'b1);
    check("abort_done", done, 1'b0);
    check("abort_result", result, 32'h0);
    check("abort_underflow", underflow, 1'b0);
    check("abort_zero", zero, 1'b0);
    repeat (15) @(negedge clk);
    send(32'h1234_5678);
    wait_idle();

    // CHUNK sweep runs in parallel on the other instances
    sweep_go = 1'b1;
    for (int k = 0; k < 6000; k++) begin
      @(posedge clk);
      if (sw[0].fin && sw[1].fin && sw[2].fin) break;
    end
    check("sweep_complete", {sw[2].fin, sw[1].fin, sw[0].fin}, 3'b111);
    check("main_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
